picomem_bridge: RTL and testbench

Memory-side bridge that services the picorv32 native memory port (valid/ready, byte strobes) from a single-port synchronous word SRAM and a memory-mapped console byte port. It sits directly downstream of the core: it decodes each request, sequences the SRAM read/write, forwards console writes over a valid/ready handshake, and flags accesses outside the mapped range. It also maintains saturating counters of instruction fetches, loads and stores for the code-compression fetch-traffic measurements.

---
 rtl/picomem_pkg.sv | 23 ++
 rtl/picomem_sat_counter.sv | 33 +++
 rtl/picomem_bridge.sv | 176 +++++++++++++++++
 tb/tb_picomem_bridge.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/picomem_pkg.sv
// ============================================================================
// Module     : picomem_pkg
// Description: Shared FSM state type and constants for picomem_bridge.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package picomem_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_WAIT  = 3'd1,
      S_RD_DATA  = 3'd2,
      S_CON_WAIT = 3'd3,
      S_RESP     = 3'd4
   } state_t;

   localparam logic [31:0] C_CONSOLE_ADDR   = 32'h1000_0000;
   localparam logic [31:0] C_UNMAPPED_RDATA = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/picomem_sat_counter.sv
// ============================================================================
// Module     : picomem_sat_counter
// Description: Saturating up-counter with synchronous clear.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module picomem_sat_counter
   import picomem_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/picomem_bridge.sv
// ============================================================================
// Module     : picomem_bridge
// Description: picorv32 native memory port to word SRAM + console byte port.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module picomem_bridge
   import picomem_pkg::*;
#(
   parameter int unsigned MEM_SIZE     = 1048576,
   parameter logic [31:0] CONSOLE_ADDR = C_CONSOLE_ADDR,
   parameter int          ADDR_W       = $clog2(MEM_SIZE / 4)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_valid,
   input  logic              mem_instr,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_wstrb,
   output logic              mem_ready,
   output logic [31:0]       mem_rdata,
   output logic              sram_en,
   output logic [3:0]        sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata,
   output logic              con_valid,
   output logic [7:0]        con_data,
   input  logic              con_ready,
   output logic              fault,
   output logic [31:0]       fault_addr,
   output logic [31:0]       cnt_ifetch,
   output logic [31:0]       cnt_load,
   output logic [31:0]       cnt_store
);

   state_t              r_state;
   logic                r_mem_ready;
   logic [31:0]         r_mem_rdata;
   logic                r_sram_en;
   logic [3:0]          r_sram_we;
   logic [ADDR_W-1:0]   r_sram_addr;
   logic [31:0]         r_sram_wdata;
   logic                r_con_valid;
   logic [7:0]          r_con_data;
   logic                r_fault;
   logic [31:0]         r_fault_addr;

   logic w_accept;
   logic w_is_write;
   logic w_is_mem;
   logic w_is_con;

   assign w_accept   = (r_state == S_IDLE) && mem_valid;
   assign w_is_write = (mem_wstrb != 4'b0000);
   assign w_is_mem   = (mem_addr < 32'(MEM_SIZE));
   assign w_is_con   = (mem_addr[31:2] == CONSOLE_ADDR[31:2]);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_mem_ready  <= 1'b0;
         r_mem_rdata  <= 32'h0;
         r_sram_en    <= 1'b0;
         r_sram_we    <= 4'b0000;
         r_sram_addr  <= '0;
         r_sram_wdata <= 32'h0;
         r_con_valid  <= 1'b0;
         r_con_data   <= 8'h00;
         r_fault      <= 1'b0;
         r_fault_addr <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mem_valid) begin
                  if (w_is_mem) begin
                     r_sram_en   <= 1'b1;
                     r_sram_addr <= mem_addr[ADDR_W+1:2];
                     if (w_is_write) begin
                        // Writes complete immediately; the SRAM commits on the next edge.
                        r_sram_we    <= mem_wstrb;
                        r_sram_wdata <= mem_wdata;
                        r_mem_ready  <= 1'b1;
                        r_state      <= S_RESP;
                     end else begin
                        r_sram_we <= 4'b0000;
                        r_state   <= S_RD_WAIT;
                     end
                  end else if (w_is_con) begin
                     if (w_is_write) begin
                        r_con_valid <= 1'b1;
                        r_con_data  <= mem_wdata[7:0];
                        r_state     <= S_CON_WAIT;
                     end else begin
                        r_mem_rdata <= C_UNMAPPED_RDATA;
                        r_mem_ready <= 1'b1;
                        r_state     <= S_RESP;
                     end
                  end else begin
                     r_fault <= 1'b1;
                     if (!r_fault) begin
                        r_fault_addr <= mem_addr;
                     end
                     if (!w_is_write) begin
                        r_mem_rdata <= C_UNMAPPED_RDATA;
                     end
                     r_mem_ready <= 1'b1;
                     r_state     <= S_RESP;
                  end
               end
            end
            S_RD_WAIT: begin
               r_state <= S_RD_DATA;
            end
            S_RD_DATA: begin
               r_mem_rdata <= sram_rdata;
               r_mem_ready <= 1'b1;
               r_state     <= S_RESP;
            end
            S_CON_WAIT: begin
               if (con_ready) begin
                  r_con_valid <= 1'b0;
                  r_mem_ready <= 1'b1;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               r_mem_ready <= 1'b0;
               r_sram_en   <= 1'b0;
               r_sram_we   <= 4'b0000;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   picomem_sat_counter #(.WIDTH(32)) u_cnt_ifetch (
      .clk     (clk),
      .i_clr   (reset),
      .i_inc   (w_accept && mem_instr),
      .o_count (cnt_ifetch)
   );

   picomem_sat_counter #(.WIDTH(32)) u_cnt_load (
      .clk     (clk),
      .i_clr   (reset),
      .i_inc   (w_accept && !mem_instr && !w_is_write),
      .o_count (cnt_load)
   );

   picomem_sat_counter #(.WIDTH(32)) u_cnt_store (
      .clk     (clk),
      .i_clr   (reset),
      .i_inc   (w_accept && !mem_instr && w_is_write),
      .o_count (cnt_store)
   );

   assign mem_ready  = r_mem_ready;
   assign mem_rdata  = r_mem_rdata;
   assign sram_en    = r_sram_en;
   assign sram_we    = r_sram_we;
   assign sram_addr  = r_sram_addr;
   assign sram_wdata = r_sram_wdata;
   assign con_valid  = r_con_valid;
   assign con_data   = r_con_data;
   assign fault      = r_fault;
   assign fault_addr = r_fault_addr;

endmodule

`default_nettype wire

// File: tb/tb_picomem_bridge.sv
// ============================================================================
// Module     : tb_picomem_bridge
// Description: Directed self-checking bench for picomem_bridge with SRAM model.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_picomem_bridge;

   localparam int ADDR_W = 18;

   logic              clk = 1'b0;
   logic              reset;
   logic              mem_valid;
   logic              mem_instr;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wstrb;
   logic              mem_ready;
   logic [31:0]       mem_rdata;
   logic              sram_en;
   logic [3:0]        sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [31:0]       sram_wdata;
   logic [31:0]       sram_rdata;
   logic              con_valid;
   logic [7:0]        con_data;
   logic              con_ready;
   logic              fault;
   logic [31:0]       fault_addr;
   logic [31:0]       cnt_ifetch;
   logic [31:0]       cnt_load;
   logic [31:0]       cnt_store;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] r_mem [0:255];

   always #5 clk = ~clk;

   picomem_bridge dut (
      .clk        (clk),
      .reset      (reset),
      .mem_valid  (mem_valid),
      .mem_instr  (mem_instr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .con_valid  (con_valid),
      .con_data   (con_data),
      .con_ready  (con_ready),
      .fault      (fault),
      .fault_addr (fault_addr),
      .cnt_ifetch (cnt_ifetch),
      .cnt_load   (cnt_load),
      .cnt_store  (cnt_store)
   );

   // Single-port synchronous SRAM: one-cycle read latency, byte-lane writes.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) begin
            r_mem[i] <= (i == 0) ? 32'h0000_0413 : 32'h0;
         end
         sram_rdata <= 32'h0;
      end else if (sram_en) begin
         if (sram_we == 4'b0000) begin
            sram_rdata <= r_mem[sram_addr[7:0]];
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (sram_we[b]) r_mem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic request(input logic instr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
      mem_valid = 1'b1;
      mem_instr = instr;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
   endtask

   task automatic idle_bus();
      mem_valid = 1'b0;
      mem_instr = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      mem_wstrb = 4'b0000;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " ready"},      {31'h0, mem_ready},  32'h0);
      check({tag, " rdata"},      mem_rdata,           32'h0);
      check({tag, " sram_en"},    {31'h0, sram_en},    32'h0);
      check({tag, " sram_we"},    {28'h0, sram_we},    32'h0);
      check({tag, " sram_addr"},  {14'h0, sram_addr},  32'h0);
      check({tag, " sram_wdata"}, sram_wdata,          32'h0);
      check({tag, " con_valid"},  {31'h0, con_valid},  32'h0);
      check({tag, " con_data"},   {24'h0, con_data},   32'h0);
      check({tag, " fault"},      {31'h0, fault},      32'h0);
      check({tag, " fault_addr"}, fault_addr,          32'h0);
      check({tag, " cnt_ifetch"}, cnt_ifetch,          32'h0);
      check({tag, " cnt_load"},   cnt_load,            32'h0);
      check({tag, " cnt_store"},  cnt_store,           32'h0);
   endtask

   initial begin
      reset     = 1'b1;
      con_ready = 1'b0;
      idle_bus();
      tick(); tick(); tick();
      reset = 1'b0;
      tick();
      check_all_zero("post_reset");

      // Fetch from 0x0: ready visible after the second edge following acceptance.
      request(1'b1, 32'h0, 32'h0, 4'b0000);
      tick();
      idle_bus();
      check("fetch en", {31'h0, sram_en}, 32'h1);
      check("fetch ready_k0", {31'h0, mem_ready}, 32'h0);
      tick();
      check("fetch ready_k1", {31'h0, mem_ready}, 32'h0);
      tick();
      check("fetch ready", {31'h0, mem_ready}, 32'h1);
      check("fetch rdata", mem_rdata, 32'h0000_0413);
      check("fetch cnt_ifetch", cnt_ifetch, 32'h1);
      tick();
      check("fetch ready_drop", {31'h0, mem_ready}, 32'h0);
      check("fetch en_drop", {31'h0, sram_en}, 32'h0);

      // Partial store, then load back the merged word.
      request(1'b0, 32'h0000_0100, 32'hAABB_CCDD, 4'b0101);
      tick();
      idle_bus();
      check("store ready", {31'h0, mem_ready}, 32'h1);
      check("store we", {28'h0, sram_we}, 32'h5);
      check("store addr", {14'h0, sram_addr}, 32'h40);
      check("store wdata", sram_wdata, 32'hAABB_CCDD);
      tick();
      check("store ready_drop", {31'h0, mem_ready}, 32'h0);
      check("store we_clear", {28'h0, sram_we}, 32'h0);
      request(1'b0, 32'h0000_0100, 32'h0, 4'b0000);
      tick();
      idle_bus();
      tick();
      tick();
      check("load ready", {31'h0, mem_ready}, 32'h1);
      check("load rdata", mem_rdata, 32'h00BB_00DD);
      check("cnt_store", cnt_store, 32'h1);
      check("cnt_load", cnt_load, 32'h1);
      tick();

      // Console write with con_ready held low for five cycles.
      request(1'b0, 32'h1000_0000, 32'h0000_0041, 4'b0001);
      tick();
      idle_bus();
      check("con valid0", {31'h0, con_valid}, 32'h1);
      check("con data0", {24'h0, con_data}, 32'h41);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("con valid_hold", {31'h0, con_valid}, 32'h1);
         check("con data_hold", {24'h0, con_data}, 32'h41);
         check("con ready_low", {31'h0, mem_ready}, 32'h0);
      end
      con_ready = 1'b1;
      tick();
      con_ready = 1'b0;
      check("con valid_drop", {31'h0, con_valid}, 32'h0);
      check("con ready", {31'h0, mem_ready}, 32'h1);
      check("con rdata_hold", mem_rdata, 32'h00BB_00DD);
      tick();
      check("con ready_once", {31'h0, mem_ready}, 32'h0);

      // Unmapped read then unmapped write; first address latched.
      request(1'b0, 32'h0010_0000, 32'h0, 4'b0000);
      tick();
      idle_bus();
      check("unm1 ready", {31'h0, mem_ready}, 32'h1);
      check("unm1 rdata", mem_rdata, 32'h0);
      check("unm1 fault", {31'h0, fault}, 32'h1);
      check("unm1 fault_addr", fault_addr, 32'h0010_0000);
      tick();
      request(1'b0, 32'h2000_0000, 32'h1234_5678, 4'b1111);
      tick();
      idle_bus();
      check("unm2 ready", {31'h0, mem_ready}, 32'h1);
      check("unm2 fault_addr", fault_addr, 32'h0010_0000);
      check("unm2 no_sram", {31'h0, sram_en}, 32'h0);
      tick();
      check("cnt_load2", cnt_load, 32'h2);
      check("cnt_store3", cnt_store, 32'h3);

      // mem_valid held through the response: exactly one acceptance.
      request(1'b1, 32'h0, 32'h0, 4'b0000);
      tick();
      tick();
      tick();
      check("hold ready", {31'h0, mem_ready}, 32'h1);
      tick();
      idle_bus();
      check("hold ready_drop", {31'h0, mem_ready}, 32'h0);
      check("hold cnt_ifetch", cnt_ifetch, 32'h2);
      tick();
      check("hold cnt_ifetch_after", cnt_ifetch, 32'h2);
      check("hold no_rerequest", {31'h0, sram_en}, 32'h0);

      // Reset during RD_WAIT.
      request(1'b0, 32'h0, 32'h0, 4'b0000);
      tick();
      idle_bus();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_all_zero("rst_rdwait");
      tick();
      check("rst_rdwait no_ready", {31'h0, mem_ready}, 32'h0);

      // Reset during CON_WAIT abandons the pending byte.
      request(1'b0, 32'h1000_0000, 32'h0000_0055, 4'b0001);
      tick();
      idle_bus();
      check("rst_con valid", {31'h0, con_valid}, 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_all_zero("rst_conwait");

      // Normal fetch after reset recovery.
      request(1'b1, 32'h0, 32'h0, 4'b0000);
      tick();
      idle_bus();
      tick();
      tick();
      check("recov ready", {31'h0, mem_ready}, 32'h1);
      check("recov rdata", mem_rdata, 32'h0000_0413);
      check("recov cnt_ifetch", cnt_ifetch, 32'h1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
